pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage ARM pipeline. It merges the three stall/flush sources into one consistent set of per-stage freeze and flush strobes:
- load/use hazard from the hazard detection unit
- taken branch resolved in EX
- multi-cycle SRAM access from the MEM stage

It tracks memory wait cycles with a watchdog FSM. It sits between the hazard unit / SRAM controller and the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/pipeline_ctrl_if.sv | 47 ++++
 rtl/pipeline_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Stall/flush bus between the hazard unit / SRAM controller and pipeline_ctrl.
// Counter signals exist only when PIPE_PERF_CNT_EN is defined.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic hazard;
  logic branch_taken;
  logic mem_req;
  logic mem_ready;
  logic freeze_pc;
  logic freeze_ifid;
  logic flush_ifid;
  logic freeze_idex;
  logic flush_idex;
  logic freeze_exmem;
  logic bubble_memwb;
  logic mem_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic [CNT_W-1:0] mem_wait_cycles;

  modport slave (
    input  hazard, branch_taken, mem_req, mem_ready,
    output freeze_pc, freeze_ifid, flush_ifid, freeze_idex, flush_idex,
           freeze_exmem, bubble_memwb, mem_timeout,
           stall_cycles, flush_events, mem_wait_cycles
  );
  modport master (
    output hazard, branch_taken, mem_req, mem_ready,
    input  freeze_pc, freeze_ifid, flush_ifid, freeze_idex, flush_idex,
           freeze_exmem, bubble_memwb, mem_timeout,
           stall_cycles, flush_events, mem_wait_cycles
  );
`else
  modport slave (
    input  hazard, branch_taken, mem_req, mem_ready,
    output freeze_pc, freeze_ifid, flush_ifid, freeze_idex, flush_idex,
           freeze_exmem, bubble_memwb, mem_timeout
  );
  modport master (
    output hazard, branch_taken, mem_req, mem_ready,
    input  freeze_pc, freeze_ifid, flush_ifid, freeze_idex, flush_idex,
           freeze_exmem, bubble_memwb, mem_timeout
  );
`endif
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with a memory-wait watchdog.
// Optional saturating performance counters are enabled by PIPE_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } stateT;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  stateT      state, nextState;
  logic [7:0] waitCnt, nextWaitCnt;
  logic       timeoutQ, nextTimeout;
  logic       memStall;

  logic freezePc, freezeIfid, flushIfid, freezeIdex, flushIdex, freezeExmem, bubbleMemwb;

  assign memStall = (state != HALT) & bus.mem_req & ~bus.mem_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      waitCnt  <= '0;
      timeoutQ <= 1'b0;
    end else begin
      state    <= nextState;
      waitCnt  <= nextWaitCnt;
      timeoutQ <= nextTimeout;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    nextState   = state;
    nextWaitCnt = waitCnt;
    nextTimeout = timeoutQ;
    unique case (state)
      RUN: begin
        if (memStall) begin
          nextState   = MEM_WAIT;
          nextWaitCnt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!memStall) begin
          nextState   = RUN;
          nextWaitCnt = '0;
        end else if (waitCnt == TIMEOUT_LAST) begin
          nextState   = HALT;
          nextTimeout = 1'b1;
        end else begin
          nextWaitCnt = waitCnt + 8'd1;
        end
      end
      HALT:    nextState = HALT;
      default: nextState = RUN;
    endcase
  end

  // Strobe priority: HALT > memory stall > taken branch > load/use hazard.
  always_comb begin
    freezePc    = 1'b0;
    freezeIfid  = 1'b0;
    flushIfid   = 1'b0;
    freezeIdex  = 1'b0;
    flushIdex   = 1'b0;
    freezeExmem = 1'b0;
    bubbleMemwb = 1'b0;
    if (!rst) begin
      if (state == HALT) begin
        freezePc    = 1'b1;
        freezeIfid  = 1'b1;
        freezeIdex  = 1'b1;
        freezeExmem = 1'b1;
      end else if (memStall) begin
        freezePc    = 1'b1;
        freezeIfid  = 1'b1;
        freezeIdex  = 1'b1;
        freezeExmem = 1'b1;
        bubbleMemwb = 1'b1;
      end else if (bus.branch_taken) begin
        flushIfid = 1'b1;
        flushIdex = 1'b1;
      end else if (bus.hazard) begin
        freezePc   = 1'b1;
        freezeIfid = 1'b1;
        flushIdex  = 1'b1;
      end
    end
  end

  assign bus.freeze_pc    = freezePc;
  assign bus.freeze_ifid  = freezeIfid;
  assign bus.flush_ifid   = flushIfid;
  assign bus.freeze_idex  = freezeIdex;
  assign bus.flush_idex   = flushIdex;
  assign bus.freeze_exmem = freezeExmem;
  assign bus.bubble_memwb = bubbleMemwb;
  assign bus.mem_timeout  = timeoutQ;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt, flushCnt, memWaitCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt   <= '0;
      flushCnt   <= '0;
      memWaitCnt <= '0;
    end else begin
      if (freezePc && (stallCnt != '1))    stallCnt   <= stallCnt + 1'b1;
      if (flushIfid && (flushCnt != '1))   flushCnt   <= flushCnt + 1'b1;
      if (memStall && (memWaitCnt != '1))  memWaitCnt <= memWaitCnt + 1'b1;
    end
  end

  assign bus.stall_cycles    = stallCnt;
  assign bus.flush_events    = flushCnt;
  assign bus.mem_wait_cycles = memWaitCnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver queues hand-computed strobes
// per cycle, the monitor pops and compares them mid-cycle.
module tb_pipeline_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  // Strobe vector order: {freeze_pc, freeze_ifid, flush_ifid, freeze_idex,
  //                       flush_idex, freeze_exmem, bubble_memwb, mem_timeout}
  localparam logic [7:0] E_IDLE = 8'b0000_0000;
  localparam logic [7:0] E_HZ   = 8'b1100_1000;
  localparam logic [7:0] E_BR   = 8'b0010_1000;
  localparam logic [7:0] E_MS   = 8'b1101_0110;
  localparam logic [7:0] E_HALT = 8'b1101_0101;

  typedef struct {
    int         idx;
    logic [7:0] strobes;
    logic       chkCnt;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic [CNT_W-1:0] mwait;
  } expT;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cycleIdx = 0;
  expT  sbQ[$];

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One cycle of stimulus: inputs applied just after the rising edge.
  task automatic step(input logic r, input logic hz, input logic br, input logic req,
                      input logic rdy, input logic [7:0] exp,
                      input logic cc = 1'b0, input int st = 0, input int fl = 0, input int mw = 0);
    expT e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.hazard       = hz;
    bus.branch_taken = br;
    bus.mem_req      = req;
    bus.mem_ready    = rdy;
    cycleIdx++;
    e.idx     = cycleIdx;
    e.strobes = exp;
    e.chkCnt  = cc;
    e.stall   = CNT_W'(st);
    e.flush   = CNT_W'(fl);
    e.mwait   = CNT_W'(mw);
    sbQ.push_back(e);
  endtask

  // Monitor: compares whatever the driver queued for the current cycle.
  initial begin
    expT        e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        e   = sbQ.pop_front();
        act = {bus.freeze_pc, bus.freeze_ifid, bus.flush_ifid, bus.freeze_idex,
               bus.flush_idex, bus.freeze_exmem, bus.bubble_memwb, bus.mem_timeout};
        check($sformatf("strobes@cycle%0d", e.idx), 32'(act), 32'(e.strobes));
`ifdef PIPE_PERF_CNT_EN
        if (e.chkCnt) begin
          check($sformatf("stall_cycles@cycle%0d", e.idx), 32'(bus.stall_cycles), 32'(e.stall));
          check($sformatf("flush_events@cycle%0d", e.idx), 32'(bus.flush_events), 32'(e.flush));
          check($sformatf("mem_wait_cycles@cycle%0d", e.idx), 32'(bus.mem_wait_cycles), 32'(e.mwait));
        end
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst              = 1'b1;
    bus.hazard       = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_ready    = 1'b0;

    // Reset, including live inputs that must be masked while rst is high.
    step(1, 0, 0, 0, 0, E_IDLE);
    step(1, 1, 1, 1, 0, E_IDLE);
    step(1, 0, 0, 0, 0, E_IDLE);
    step(0, 0, 0, 0, 0, E_IDLE, 1, 0, 0, 0);
    // Hazard twice, then branch wins over hazard.
    step(0, 1, 0, 0, 0, E_HZ);
    step(0, 1, 0, 0, 0, E_HZ);
    step(0, 1, 1, 0, 0, E_BR);
    step(0, 0, 0, 0, 0, E_IDLE);
    // Three-cycle memory wait; the ready cycle is not stalled.
    step(0, 0, 0, 1, 0, E_MS);
    step(0, 0, 0, 1, 0, E_MS);
    step(0, 0, 0, 1, 0, E_MS);
    step(0, 0, 0, 1, 1, E_IDLE);
    step(0, 0, 0, 0, 0, E_IDLE, 1, 5, 1, 3);
    // Zero-wait access from RUN.
    step(0, 0, 0, 1, 1, E_IDLE);
    // All sources at once: memory stall wins; then request withdrawn.
    step(0, 1, 1, 1, 0, E_MS);
    step(0, 0, 1, 0, 0, E_BR);
    step(0, 0, 0, 0, 0, E_IDLE);
    // Watchdog: four stalled cycles, then HALT with mem_timeout.
    step(0, 0, 0, 1, 0, E_MS);
    step(0, 0, 0, 1, 0, E_MS);
    step(0, 0, 0, 1, 0, E_MS);
    step(0, 0, 0, 1, 0, E_MS);
    step(0, 0, 0, 1, 0, E_HALT);
    step(0, 1, 1, 0, 0, E_HALT);
    step(0, 0, 0, 0, 0, E_HALT, 1, 12, 2, 8);
    // Reset leaves HALT; pipeline resumes in RUN.
    step(1, 1, 0, 0, 0, E_IDLE);
    step(0, 0, 0, 0, 0, E_IDLE, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, E_HZ);
    // Long hazard: stall counter saturates at 15.
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, E_HZ);
    step(0, 0, 0, 0, 0, E_IDLE, 1, 15, 0, 0);

    @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
